dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit data words; word-addressed, matching the core's word-addressed memories.
REQ-002 Parameter LATENCY, default 2, legal range 1..7: cycles from request acceptance to response valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  responder accepts the request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  word address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for a store; bit n covers bits [8n+7:8n].
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core consumes the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid, latch write, addr, wdata and be; load the counter with LATENCY-1; go to WAIT.
REQ-017 WAIT: req_ready=0; decrement the counter each cycle; at count 0, perform the access and go to RESP.
REQ-018 Accept-to-rsp_valid latency SHALL equal exactly LATENCY cycles, i.e. rsp_valid rises LATENCY edges after the accepting edge.
REQ-019 The access SHALL be a load (rsp_rdata = mem[addr]) or a store (update only the bytes whose be bit is 1; rsp_rdata=0).
REQ-020 A store with be=0000 SHALL complete normally with no memory change.
REQ-021 An out-of-range address SHALL cause no memory write, rsp_rdata=0 and rsp_err=1.
REQ-022 RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-023 A handshake in RESP SHALL NOT overlap a new acceptance; req_ready is first 1 on the cycle after the response handshake.
REQ-024 At most one transaction SHALL be outstanding; req_* inputs are ignored outside IDLE.
REQ-025 Address comparison SHALL use the full 32 bits; there is no wrap-around or aliasing.
REQ-026 A load following a store to the same address SHALL return the stored data.

Reset
REQ-027 While rst=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, latched request cleared.
REQ-028 req_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 A reset during WAIT or RESP SHALL abort the transaction; a pending store SHALL NOT modify memory.
REQ-030 Memory array contents SHALL NOT be reset.

Structure
REQ-031 A shared package riscv_mem_pkg SHALL hold the FSM state encoding (2 bits), the counter width constant (3) and the default DEPTH/LATENCY values.
REQ-032 A single sub-module dmem_array SHALL implement the byte-enabled synchronous RAM (one port: we, be[3:0], addr, wdata, rdata); the FSM, counter and address check stay in dmem_responder.

Verification
REQ-033 Reset sequence: rst low for 3 cycles, then high -> all outputs 0 during reset; req_ready=1 on the next edge.
REQ-034 Store then load, LATENCY=2: store addr=5, wdata=0xDEADBEEF, be=1111; then load addr=5 -> each rsp_valid exactly 2 cycles after acceptance; load returns 0xDEADBEEF with rsp_err=0.
REQ-035 Partial store: mem[7]=0x11223344, then store be=0010, wdata=0x0000AA00 -> subsequent load returns 0x1122AA44.
REQ-036 Backpressure: hold rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; IDLE is reached one cycle after rsp_ready=1.
REQ-037 Out of range, DEPTH=256: store addr=256 -> rsp_err=1, rsp_rdata=0; load addr=0 is unchanged.
REQ-038 Abort: assert rst in WAIT during a store to addr=9 holding 0x0 -> after reset, load addr=9 returns 0x0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter width,
// default geometry and the latched-request record.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CNT_W           = 3;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;

    typedef struct packed {
        logic        write;
        logic        err;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled synchronous RAM of 32-bit words; contents are never reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, IDLE/WAIT/RESP
// handshake FSM with a latency counter and full-width range check.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    req_t            req_q;
    logic [AW-1:0]   addr_q;
    logic            live;
    logic            accept;
    logic            access;
    logic [31:0]     arr_rdata;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        access    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = live;
                if (live && req_valid) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = req_ready && req_valid;

    // live holds req_ready low until the first edge after reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            live   <= 1'b0;
            cnt    <= '0;
            req_q  <= '0;
            addr_q <= '0;
        end else begin
            live  <= 1'b1;
            state <= state_nxt;
            if (accept) begin
                req_q.write <= req_write;
                req_q.err   <= (req_addr >= DEPTH_W);
                req_q.wdata <= req_wdata;
                req_q.be    <= req_be;
                addr_q      <= req_addr[AW-1:0];
                cnt         <= CNT_W'(LATENCY - 1);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Array read data stays stable through RESP: addr_q is frozen and no write is issued.
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (access && req_q.write && !req_q.err),
        .be    (req_q.be),
        .addr  (addr_q),
        .wdata (req_q.wdata),
        .rdata (arr_rdata)
    );

    assign rsp_rdata = (rsp_valid && !req_q.write && !req_q.err) ? arr_rdata : 32'h0;
    assign rsp_err   = rsp_valid && req_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One full transaction; rsp_ready held low for 'hold' cycles after rsp_valid.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err);
        int g;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " accept"}, 32'(g < 20), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // reset held for 3 cycles, outputs low throughout
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst req_ready", 32'(req_ready), 32'd0);
            chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst rsp_rdata", rsp_rdata, 32'h0);
            chk("rst rsp_err", 32'(rsp_err), 32'd0);
        end
        rst = 1'b1;
        #1 chk("post-rst before edge req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("post-rst req_ready", 32'(req_ready), 32'd1);

        txn("st5",  1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        txn("ld5",  1'b0, 32'd5, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        txn("st7",  1'b1, 32'd7, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        txn("st7p", 1'b1, 32'd7, 32'h0000AA00, 4'b0010, 0, 32'h0, 1'b0);
        txn("ld7",  1'b0, 32'd7, 32'h0, 4'h0, 0, 32'h1122AA44, 1'b0);
        txn("bp5",  1'b0, 32'd5, 32'h0, 4'h0, 4, 32'hDEADBEEF, 1'b0);
        txn("be0",  1'b1, 32'd5, 32'h12345678, 4'h0, 0, 32'h0, 1'b0);
        txn("ld5b", 1'b0, 32'd5, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        txn("st0",  1'b1, 32'd0, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0);
        txn("st256", 1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        txn("ld0",  1'b0, 32'd0, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);
        txn("sthi", 1'b1, 32'h80000005, 32'h0BADF00D, 4'hF, 0, 32'h0, 1'b1);
        txn("ld5c", 1'b0, 32'd5, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        txn("ld300", 1'b0, 32'd300, 32'h0, 4'h0, 2, 32'h0, 1'b1);

        // abort a store in WAIT
        txn("st9",  1'b1, 32'd9, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd9;
        req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        txn("ld9",  1'b0, 32'd9, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
